multi_cycle_cpu: RTL
====================

# multi_cycle_cpu

Parametrised multi-cycle successor to the single-cycle MIPS-subset core. Executes each instruction over several states of one FSM and shares a single ALU across them. Talks to external instruction and data memories through req/ack handshakes, so wait-state memories are supported. Adds lw/sw, bne, j, slti and an illegal-opcode mode; it is the top-level core for the lab platform.

## Interface
- ADDR_W, 32: width of the PC and of both memory address ports (8..32); the datapath is fixed at 32 bits.
- RESET_PC, 0: PC value loaded on reset (word aligned).
- HALT_ON_ILLEGAL, 1: 1 = unknown opcode enters HALT; 0 = unknown opcode retires as a NOP.

- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- imem_req_o  out  1  instruction fetch request, held until ack.
- imem_addr_o  out  ADDR_W  fetch address (= PC).
- imem_ack_i  in  1  fetch complete; imem_rdata_i is valid in the same cycle.
- imem_rdata_i  in  32  instruction word.
- dmem_req_o  out  1  data access request, held until ack.
- dmem_we_o  out  1  1 = store, 0 = load.
- dmem_addr_o  out  ADDR_W  ALU result truncated to ADDR_W.
- dmem_wdata_o  out  32  store data (rt).
- dmem_ack_i  in  1  access complete; dmem_rdata_i is valid in the same cycle for loads.
- dmem_rdata_i  in  32  load data.
- retire_o  out  1  one-cycle pulse on the final cycle of each retired instruction.
- halted_o  out  1  core is in HALT.
- pc_o  out  ADDR_W  current PC, for debug.

## Operation
- Supported instructions:
  - R-type (op 0): funct 32 add, 34 sub, 36 and, 37 or, 42 slt (signed).
  - Immediate: addi (8) and slti (10), immediate sign-extended.
  - Branches: beq (4), bne (5).
  - Memory: lw (35), sw (43).
  - Jump: j (2), target = {PC+4[ADDR_W-1:28], imm26, 2'b00}, truncated to ADDR_W.
  - An unknown R-type funct is treated as an illegal instruction.
- Arithmetic: add, sub and addi wrap modulo 2^32 with no overflow trap.
- Register file: 32x32. r0 reads 0 and writes to it are discarded. Two asynchronous read ports, one synchronous write port.
- State flow:
  - FETCH: imem_req_o=1. On ack, latch IR, set PC <= PC+4, go DECODE.
  - DECODE: latch A=rs and B=rt; compute branch target = PC + (sext(imm) << 2).
    - j: load PC, retire, go FETCH.
    - Illegal: HALT if HALT_ON_ILLEGAL=1, otherwise retire and go FETCH.
    - All other instructions: go EXEC.
  - EXEC: ALU operates.
    - beq/bne: if the condition holds, load the target into PC; retire and go FETCH.
    - lw/sw: go MEM.
    - Otherwise: go WB.
  - MEM: dmem_req_o=1. On ack, sw retires and goes FETCH; lw latches MDR and goes WB.
  - WB: write rd (R-type), rt (addi/slti) or MDR→rt (lw); retire and go FETCH.
  - HALT: absorbing state, left only through reset. No requests are issued.
- Request signals are registered-state decodes and are glitch-free. Address and data are stable while req is high.

## Timing
- Reset values: all outputs 0 except pc_o=RESET_PC. State=FETCH and all registers cleared.
- Reset assertion mid-transaction drops req immediately; any late ack is ignored.
- The first fetch request appears in the first cycle after reset is released.
- Ack may arrive in the same cycle req rises (zero-wait), or any number of cycles later.
- An ack while req=0 is ignored.
- Cycles per instruction at zero wait; each memory wait cycle adds 1:
  - j: 2
  - illegal-as-NOP: 2
  - beq/bne: 3
  - R-type, addi, slti, sw: 4
  - lw: 5
- A register written in WB is visible to the next instruction's DECODE, so no hazard exists.
- A branch to its own address loops indefinitely. The PC wraps modulo 2^ADDR_W.

## Structure
- Package cpu_pkg holds:
  - opcode and funct localparams;
  - ALU control codes;
  - the state enum (FETCH, DECODE, EXEC, MEM, WB, HALT).
- Sub-module mc_regfile holds the register file, with r0 hardwired to 0.
- ALU, control FSM and datapath registers (IR, A, B, ALUOut, MDR, PC) live in the top level.

## Test plan
- Zero-wait ALU mix:
  - Stimulus: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1.
  - Response: r3=2, r4=1, 4 retire pulses, 16 cycles total.
- Memory with waits, using 2-cycle ack latency on both ports:
  - Stimulus: sw r1,8(r0) then lw r5,8(r0).
  - Response: dmem_addr_o=8, dmem_wdata_o=5, r5=5; req held through the wait cycles; lw takes 5+4 cycles.
- Branches and jump:
  - beq r1,r1,+2 at PC 0x10 gives next fetch at 0x1C.
  - bne r1,r1 falls through to 0x14.
  - j 0x40 fetches 0x100.
- Illegal opcode 0x3F:
  - HALT_ON_ILLEGAL=1: halted_o=1 two cycles after the fetch ack, and no further imem_req_o.
  - HALT_ON_ILLEGAL=0: retires, and PC advances by 4.
- r0 and wrap:
  - Writing r0 with 7 leaves r0 reading 0.
  - addi from 0x7FFFFFFF with +1 gives 0x80000000.
- Reset mid-MEM:
  - Stimulus: drop rst_i while dmem_req_o=1.
  - Response: dmem_req_o falls in the same cycle; after release, fetch restarts at RESET_PC with all registers 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: opcodes, functs,
// ALU control codes and the control FSM state encoding.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_ctl_e;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_e;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: return (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_LW, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic alu_ctl_e funct_to_alu(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, r0 always reads zero.
module mc_regfile
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [32];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core with one shared ALU and req/ack instruction
// and data memory ports.
//
// state  | meaning
// FETCH  | request instruction at PC; on ack latch IR and advance PC by 4
// DECODE | read rs/rt into A/B, ALU forms branch target; j and NOP-illegal retire
// EXEC   | ALU operates; branches resolve and retire
// MEM    | data access for lw/sw; sw retires on ack
// WB     | register write-back, retire
// HALT   | illegal instruction seen, no further requests until reset
module multi_cycle_cpu
  import cpu_pkg::*;
#(
  parameter int                ADDR_W          = 32,
  parameter logic [ADDR_W-1:0] RESET_PC        = '0,
  parameter bit                HALT_ON_ILLEGAL = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic              retire_o,
  output logic              halted_o,
  output logic [ADDR_W-1:0] pc_o
);

  state_e            state_q, state_d;
  logic              run_q;
  logic [31:0]       ir_q, a_q, b_q, aluout_q, mdr_q;
  logic [ADDR_W-1:0] pc_q;

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sext, pc_ext, jump_tgt;
  logic        legal, is_branch, is_mem, take;
  logic        fetch_done, mem_done;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign fn       = ir_q[5:0];
  assign sext     = {{16{ir_q[15]}}, ir_q[15:0]};
  assign pc_ext   = 32'(pc_q);
  assign jump_tgt = {pc_ext[31:28], ir_q[25:0], 2'b00};
  assign legal    = is_legal(op, fn);
  assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
  assign is_mem    = (op == OP_LW) || (op == OP_SW);

  // run_q keeps FETCH quiet during reset and for the release cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  assign imem_req_o = run_q && (state_q == FETCH);
  assign dmem_req_o = (state_q == MEM);
  assign fetch_done = imem_req_o && imem_ack_i;
  assign mem_done   = dmem_req_o && dmem_ack_i;

  logic [31:0] alu_a, alu_b, alu_y;
  alu_ctl_e    alu_ctl;
  logic        alu_zero;

  always_comb begin
    alu_a   = a_q;
    alu_b   = b_q;
    alu_ctl = ALU_ADD;
    if (state_q == DECODE) begin
      alu_a = pc_ext;
      alu_b = {sext[29:0], 2'b00};
    end else begin
      case (op)
        OP_RTYPE:             alu_ctl = funct_to_alu(fn);
        OP_ADDI, OP_LW, OP_SW: alu_b  = sext;
        OP_SLTI: begin
          alu_b   = sext;
          alu_ctl = ALU_SLT;
        end
        OP_BEQ, OP_BNE:       alu_ctl = ALU_SUB;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (alu_ctl)
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = alu_a + alu_b;
    endcase
  end

  assign alu_zero = (alu_y == 32'd0);
  assign take     = (op == OP_BEQ) ? alu_zero : !alu_zero;

  logic [31:0] rf_rd1, rf_rd2, rf_wd;
  logic [4:0]  rf_wa;
  logic        rf_we;

  assign rf_we = (state_q == WB);
  assign rf_wa = (op == OP_RTYPE) ? rd : rt;
  assign rf_wd = (op == OP_LW) ? mdr_q : aluout_q;

  mc_regfile u_regfile (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2),
    .we    (rf_we),
    .wa    (rf_wa),
    .wd    (rf_wd)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    retire_o = 1'b0;
    case (state_q)
      FETCH: if (fetch_done) state_d = DECODE;
      DECODE: begin
        if (!legal) begin
          if (HALT_ON_ILLEGAL) begin
            state_d = HALT;
          end else begin
            state_d  = FETCH;
            retire_o = 1'b1;
          end
        end else if (op == OP_J) begin
          state_d  = FETCH;
          retire_o = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_branch) begin
          state_d  = FETCH;
          retire_o = 1'b1;
        end else if (is_mem) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (mem_done) begin
          if (op == OP_SW) begin
            state_d  = FETCH;
            retire_o = 1'b1;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        state_d  = FETCH;
        retire_o = 1'b1;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Branch target is parked in aluout_q during DECODE and consumed in EXEC.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      pc_q     <= RESET_PC;
    end else begin
      case (state_q)
        FETCH: begin
          if (fetch_done) begin
            ir_q <= imem_rdata_i;
            pc_q <= pc_q + ADDR_W'(4);
          end
        end
        DECODE: begin
          a_q      <= rf_rd1;
          b_q      <= rf_rd2;
          aluout_q <= alu_y;
          if (op == OP_J) pc_q <= ADDR_W'(jump_tgt);
        end
        EXEC: begin
          if (is_branch) begin
            if (take) pc_q <= ADDR_W'(aluout_q);
          end else begin
            aluout_q <= alu_y;
          end
        end
        MEM: if (mem_done && (op == OP_LW)) mdr_q <= dmem_rdata_i;
        default: ;
      endcase
    end
  end

  assign imem_addr_o  = imem_req_o ? pc_q : '0;
  assign dmem_we_o    = dmem_req_o && (op == OP_SW);
  assign dmem_addr_o  = ADDR_W'(aluout_q);
  assign dmem_wdata_o = b_q;
  assign halted_o     = (state_q == HALT);
  assign pc_o         = pc_q;

endmodule
